// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iir_pkg
// Brief    : Shared types and N_BITS reduction helper for iir_biquad_tdm.
//            IIR_SATURATE_EN selects saturating (defined) or wrapping reduction.
// Revision : 1.0 - initial release
// ============================================================================
package iir_pkg;

  localparam int c_DEF_FRAC_BITS = 16;
  localparam int c_RED_W         = 128;

  typedef enum logic [2:0] {
    CS_B0     = 3'd0,
    CS_B1     = 3'd1,
    CS_B2     = 3'd2,
    CS_A1     = 3'd3,
    CS_A2     = 3'd4,
    CS_OFFSET = 3'd5
  } coef_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FB1  = 3'd1,
    ST_FB2  = 3'd2,
    ST_FF0  = 3'd3,
    ST_FF1  = 3'd4,
    ST_FF2  = 3'd5,
    ST_DONE = 3'd6
  } iir_state_t;

  // Reduces a sign-extended value to i_n bits; result is returned sign-extended.
  function automatic logic signed [c_RED_W-1:0] reduce_to_n(
    input logic signed [c_RED_W-1:0] i_v,
    input int                        i_n
  );
    logic signed [c_RED_W-1:0] res;
`ifdef IIR_SATURATE_EN
    logic signed [c_RED_W-1:0] v_max;
    logic signed [c_RED_W-1:0] v_min;
    for (int i = 0; i < c_RED_W; i++) begin
      v_max[i] = (i < i_n - 1);
    end
    v_min = ~v_max;
    if (i_v > v_max) begin
      res = v_max;
    end else if (i_v < v_min) begin
      res = v_min;
    end else begin
      res = i_v;
    end
`else
    logic sgn;
    sgn = 1'b0;
    for (int i = 0; i < c_RED_W; i++) begin
      if (i == i_n - 1) sgn = i_v[i];
    end
    for (int i = 0; i < c_RED_W; i++) begin
      res[i] = (i < i_n) ? i_v[i] : sgn;
    end
`endif
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iir_mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : iir_mac_unit
// Brief    : Combinational signed Q-format multiply, shift and accumulate.
// Revision : 1.0 - initial release
// ============================================================================
module iir_mac_unit #(
  parameter int N_BITS    = 32,
  parameter int FRAC_BITS = 16,
  parameter int ACC_W     = 34
) (
  input  logic signed [N_BITS-1:0] i_a,
  input  logic signed [N_BITS-1:0] i_b,
  input  logic signed [ACC_W-1:0]  i_base,
  input  logic                     i_sub,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*N_BITS-1:0] w_prod;
  logic signed [2*N_BITS-1:0] w_shift;
  logic signed [ACC_W-1:0]    w_term;

  assign w_prod  = (2*N_BITS)'(i_a) * (2*N_BITS)'(i_b);
  // Arithmetic shift floors toward -inf; the guard bits absorb transient growth.
  assign w_shift = w_prod >>> FRAC_BITS;
  assign w_term  = ACC_W'(w_shift);
  assign o_acc   = i_sub ? (i_base - w_term) : (i_base + w_term);

endmodule
`default_nettype wire

// File: rtl/iir_biquad_tdm.sv
`default_nettype none
// ============================================================================
// Module   : iir_biquad_tdm
// Brief    : N_CH-channel time-multiplexed DF-II biquad on one shared MAC.
//            Reduction mode set by IIR_SATURATE_EN (see iir_pkg).
// Revision : 1.0 - initial release
// ============================================================================
module iir_biquad_tdm
  import iir_pkg::*;
#(
  parameter int  N_BITS    = 32,
  parameter int  FRAC_BITS = c_DEF_FRAC_BITS,
  parameter int  N_CH      = 4,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CH_W-1:0]   in_ch_i,
  input  logic [N_BITS-1:0] x_i,
  input  logic              coef_we_i,
  input  logic [CH_W-1:0]   coef_ch_i,
  input  logic [2:0]        coef_sel_i,
  input  logic [N_BITS-1:0] coef_i,
  output logic              out_valid_o,
  output logic [CH_W-1:0]   out_ch_o,
  output logic [N_BITS-1:0] y_o
);

  localparam int            c_ACC_W  = N_BITS + 2;
  localparam int            c_N_COEF = 6;
  localparam logic [CH_W:0] c_N_CH   = (CH_W + 1)'(N_CH);

  iir_state_t                r_state;
  logic [CH_W-1:0]           r_ch;
  logic signed [N_BITS-1:0]  r_x;
  logic signed [N_BITS-1:0]  r_w0;
  logic signed [c_ACC_W-1:0] r_acc;
  logic [N_BITS-1:0]         r_y;
  logic                      r_out_valid;
  logic [CH_W-1:0]           r_out_ch;
  logic signed [N_BITS-1:0]  r_coef [N_CH][c_N_COEF];
  logic signed [N_BITS-1:0]  r_w1   [N_CH];
  logic signed [N_BITS-1:0]  r_w2   [N_CH];

  logic                      w_accept;
  logic                      w_in_ch_ok;
  logic                      w_coef_ok;
  logic signed [N_BITS-1:0]  w_offset;
  logic signed [N_BITS:0]    w_x_sum;
  logic signed [N_BITS-1:0]  w_x_red;
  logic signed [N_BITS-1:0]  w_mul_a;
  logic signed [N_BITS-1:0]  w_mul_b;
  logic signed [c_ACC_W-1:0] w_base;
  logic                      w_sub;
  logic signed [c_ACC_W-1:0] w_mac;
  logic signed [N_BITS-1:0]  w_mac_red;

  assign w_in_ch_ok = ({1'b0, in_ch_i} < c_N_CH);
  assign w_coef_ok  = coef_we_i && ({1'b0, coef_ch_i} < c_N_CH) && (coef_sel_i <= CS_OFFSET);
  assign w_accept   = in_valid_i && (r_state == ST_IDLE);

  // An offset write landing on the accept edge for the same channel is forwarded.
  assign w_offset = (w_coef_ok && (coef_ch_i == in_ch_i) && (coef_sel_i == CS_OFFSET))
                    ? coef_i : r_coef[in_ch_i][CS_OFFSET];
  assign w_x_sum   = (N_BITS + 1)'(signed'(x_i)) + (N_BITS + 1)'(w_offset);
  assign w_x_red   = N_BITS'(reduce_to_n(c_RED_W'(w_x_sum), N_BITS));
  assign w_mac_red = N_BITS'(reduce_to_n(c_RED_W'(w_mac), N_BITS));

  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    w_base  = '0;
    w_sub   = 1'b0;
    case (r_state)
      ST_FB1: begin
        w_mul_a = r_coef[r_ch][CS_A1];
        w_mul_b = r_w1[r_ch];
        w_base  = c_ACC_W'(r_x);
        w_sub   = 1'b1;
      end
      ST_FB2: begin
        w_mul_a = r_coef[r_ch][CS_A2];
        w_mul_b = r_w2[r_ch];
        w_base  = r_acc;
        w_sub   = 1'b1;
      end
      ST_FF0: begin
        w_mul_a = r_coef[r_ch][CS_B0];
        w_mul_b = r_w0;
      end
      ST_FF1: begin
        w_mul_a = r_coef[r_ch][CS_B1];
        w_mul_b = r_w1[r_ch];
        w_base  = r_acc;
      end
      ST_FF2: begin
        w_mul_a = r_coef[r_ch][CS_B2];
        w_mul_b = r_w2[r_ch];
        w_base  = r_acc;
      end
      default: ;
    endcase
  end

  iir_mac_unit #(
    .N_BITS    (N_BITS),
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (c_ACC_W)
  ) u_mac (
    .i_a    (w_mul_a),
    .i_b    (w_mul_b),
    .i_base (w_base),
    .i_sub  (w_sub),
    .o_acc  (w_mac)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ch        <= '0;
      r_x         <= '0;
      r_w0        <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        // Out-of-range channels are consumed here without entering the pipeline.
        ST_IDLE: begin
          if (w_accept && w_in_ch_ok) begin
            r_ch    <= in_ch_i;
            r_x     <= w_x_red;
            r_state <= ST_FB1;
          end
        end
        ST_FB1: begin
          r_acc   <= w_mac;
          r_state <= ST_FB2;
        end
        ST_FB2: begin
          r_w0    <= w_mac_red;
          r_state <= ST_FF0;
        end
        ST_FF0: begin
          r_acc   <= w_mac;
          r_state <= ST_FF1;
        end
        ST_FF1: begin
          r_acc   <= w_mac;
          r_state <= ST_FF2;
        end
        ST_FF2: begin
          r_y         <= w_mac_red;
          r_out_ch    <= r_ch;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        r_w1[c] <= '0;
        r_w2[c] <= '0;
        for (int k = 0; k < c_N_COEF; k++) begin
          r_coef[c][k] <= '0;
        end
      end
    end else begin
      if (w_coef_ok) begin
        r_coef[coef_ch_i][coef_sel_i] <= coef_i;
      end
      // Delay line advances only once the result is committed.
      if (r_state == ST_FF2) begin
        r_w2[r_ch] <= r_w1[r_ch];
        r_w1[r_ch] <= r_w0;
      end
    end
  end

  assign in_ready_o  = (r_state == ST_IDLE);
  assign out_valid_o = r_out_valid;
  assign out_ch_o    = r_out_ch;
  assign y_o         = r_y;

endmodule
`default_nettype wire

// File: tb/tb_iir_biquad_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_biquad_tdm
// Brief    : Self-checking bench for iir_biquad_tdm against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir_biquad_tdm;

  localparam int N_BITS = 32;
  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam longint c_MAX = 64'sd2147483647;
  localparam longint c_MIN = -64'sd2147483648;

  typedef struct {
    int          due;
    int          ch;
    logic [31:0] y;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [CH_W-1:0]   in_ch_i;
  logic [N_BITS-1:0] x_i;
  logic              coef_we_i;
  logic [CH_W-1:0]   coef_ch_i;
  logic [2:0]        coef_sel_i;
  logic [N_BITS-1:0] coef_i;
  logic              out_valid_o;
  logic [CH_W-1:0]   out_ch_o;
  logic [N_BITS-1:0] y_o;

  always #5 clk = ~clk;

  iir_biquad_tdm #(.N_BITS(N_BITS), .FRAC_BITS(16), .N_CH(N_CH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_ch_i     (in_ch_i),
    .x_i         (x_i),
    .coef_we_i   (coef_we_i),
    .coef_ch_i   (coef_ch_i),
    .coef_sel_i  (coef_sel_i),
    .coef_i      (coef_i),
    .out_valid_o (out_valid_o),
    .out_ch_o    (out_ch_o),
    .y_o         (y_o)
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  exp_t        exp_q[$];
  logic [31:0] hold_y;
  int          hold_ch;
  longint      m_coef [N_CH][6];
  longint      m_w1   [N_CH];
  longint      m_w2   [N_CH];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint s32(input logic [31:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic longint red(input longint v);
`ifdef IIR_SATURATE_EN
    if (v > c_MAX) return c_MAX;
    if (v < c_MIN) return c_MIN;
    return v;
`else
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
`endif
  endfunction

  function automatic longint wrap34(input longint v);
    logic signed [33:0] t;
    t = v[33:0];
    return longint'(t);
  endfunction

  function automatic longint mq(input longint a, input longint b);
    return (a * b) >>> 16;
  endfunction

  // y = b0*w0 + b1*w1 + b2*w2 with w0 = (x + offset) - a1*w1 - a2*w2.
  function automatic logic [31:0] model_step(input int ch, input logic [31:0] xr);
    longint x, acc, w0, y;
    x   = red(s32(xr) + m_coef[ch][5]);
    acc = wrap34(x - mq(m_coef[ch][3], m_w1[ch]));
    acc = wrap34(acc - mq(m_coef[ch][4], m_w2[ch]));
    w0  = red(acc);
    acc = wrap34(mq(m_coef[ch][0], w0));
    acc = wrap34(acc + mq(m_coef[ch][1], m_w1[ch]));
    acc = wrap34(acc + mq(m_coef[ch][2], m_w2[ch]));
    y   = red(acc);
    m_w2[ch] = m_w1[ch];
    m_w1[ch] = w0;
    return 32'(y);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_w1[c] = 0;
      m_w2[c] = 0;
      for (int s = 0; s < 6; s++) m_coef[c][s] = 0;
    end
    exp_q.delete();
    hold_y  = '0;
    hold_ch = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic wcoef(input int ch, input int sel, input logic [31:0] val);
    coef_we_i  = 1'b1;
    coef_ch_i  = CH_W'(ch);
    coef_sel_i = 3'(sel);
    coef_i     = val;
    @(posedge clk); #1;
    coef_we_i  = 1'b0;
    if (sel < 6) m_coef[ch][sel] = s32(val);
  endtask

  task automatic send(input int ch, input logic [31:0] x, input bit do_w,
                      input int wsel, input logic [31:0] wval, output int k);
    exp_t e;
    int   guard = 0;
    while (!in_ready_o && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready_o) begin
      check("ready_timeout", 32'(in_ready_o), 32'd1);
      k = cyc;
      return;
    end
    in_valid_i = 1'b1;
    in_ch_i    = CH_W'(ch);
    x_i        = x;
    if (do_w) begin
      coef_we_i  = 1'b1;
      coef_ch_i  = CH_W'(ch);
      coef_sel_i = 3'(wsel);
      coef_i     = wval;
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    coef_we_i  = 1'b0;
    k = cyc;
    if (do_w && wsel < 6) m_coef[ch][wsel] = s32(wval);
    e.due = k + 5;
    e.ch  = ch;
    e.y   = model_step(ch, x);
    exp_q.push_back(e);
  endtask

  task automatic wait_out(input string name, input int k, input logic [31:0] lit, input int lch);
    int n = 0;
    while (n < 12) begin
      @(negedge clk);
      if (out_valid_o) break;
      n++;
    end
    check({name, "_strobe"}, 32'(out_valid_o), 32'd1);
    check({name, "_latency"}, 32'(cyc - k), 32'd5);
    check(name, y_o, lit);
    check({name, "_ch"}, 32'(out_ch_o), 32'(lch));
  endtask

  // Per-cycle comparison against the model's expected strobe/hold behaviour.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("model_strobe", 32'(out_valid_o), 32'd1);
        check("model_y", y_o, exp_q[0].y);
        check("model_ch", 32'(out_ch_o), 32'(exp_q[0].ch));
        hold_y  = exp_q[0].y;
        hold_ch = exp_q[0].ch;
        void'(exp_q.pop_front());
      end else if (!reset) begin
        check("no_strobe", 32'(out_valid_o), 32'd0);
        check("y_hold", y_o, hold_y);
        check("ch_hold", 32'(out_ch_o), 32'(hold_ch));
      end
    end
  end

  initial begin
    int k;
    reset      = 1'b1;
    in_valid_i = 1'b0;
    in_ch_i    = '0;
    x_i        = '0;
    coef_we_i  = 1'b0;
    coef_ch_i  = '0;
    coef_sel_i = '0;
    coef_i     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", 32'(in_ready_o), 32'd1);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_y", y_o, 32'h0);

    send(0, 32'h00020000, 1'b0, 0, 32'h0, k);
    wait_out("zero_coef", k, 32'h00000000, 0);

    wcoef(0, 0, 32'h00010000);
    send(0, 32'h00020000, 1'b0, 0, 32'h0, k);
    wait_out("unity_b0", k, 32'h00020000, 0);

    send(0, 32'h0, 1'b0, 0, 32'h0, k);
    send(0, 32'h0, 1'b0, 0, 32'h0, k);
    wcoef(0, 3, 32'hFFFF8000);
    send(0, 32'h00010000, 1'b0, 0, 32'h0, k);
    wait_out("imp0", k, 32'h00010000, 0);
    send(0, 32'h0, 1'b0, 0, 32'h0, k);
    wait_out("imp1", k, 32'h00008000, 0);
    send(0, 32'h0, 1'b0, 0, 32'h0, k);
    wait_out("imp2", k, 32'h00004000, 0);

    wcoef(1, 0, 32'h00020000);
    send(1, 32'h00030000, 1'b0, 0, 32'h0, k);
    wait_out("ch1_a", k, 32'h00060000, 1);
    send(0, 32'h0, 1'b0, 0, 32'h0, k);
    wait_out("imp3", k, 32'h00002000, 0);
    send(1, 32'hFFFF0000, 1'b0, 0, 32'h0, k);
    wait_out("ch1_b", k, 32'hFFFE0000, 1);
    send(0, 32'h0, 1'b0, 0, 32'h0, k);
    wait_out("imp4", k, 32'h00001000, 0);

    wcoef(2, 0, 32'h7FFF0000);
    send(2, 32'h00040000, 1'b0, 0, 32'h0, k);
`ifdef IIR_SATURATE_EN
    wait_out("reduce", k, 32'h7FFFFFFF, 2);
`else
    wait_out("reduce", k, 32'hFFFC0000, 2);
`endif

    wcoef(3, 5, 32'h00010000);
    wcoef(3, 0, 32'h00010000);
    send(3, 32'h0, 1'b0, 0, 32'h0, k);
    wait_out("offset", k, 32'h00010000, 3);
    send(3, 32'h0, 1'b1, 5, 32'h00020000, k);
    wait_out("offset_bypass", k, 32'h00020000, 3);

    // Abort a sample while it is in the FF0 step.
    send(0, 32'h00010000, 1'b0, 0, 32'h0, k);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("abort_ready", 32'(in_ready_o), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    wcoef(0, 1, 32'h00010000);
    wcoef(0, 2, 32'h00010000);
    send(0, 32'h00050000, 1'b0, 0, 32'h0, k);
    wait_out("state_cleared", k, 32'h00000000, 0);

    for (int c = 0; c < N_CH; c++) wcoef(c, 0, 32'h00010000);
    for (int it = 0; it < 60; it++) begin
      int          ch;
      int          wsel;
      bit          do_w;
      logic [31:0] x;
      logic [31:0] v;
      ch   = int'($urandom_range(0, N_CH - 1));
      x    = 32'($urandom_range(0, 32'h0007FFFF)) - 32'h00040000;
      v    = 32'($urandom_range(0, 32'h00008000)) - 32'h00004000;
      wsel = int'($urandom_range(0, 7));
      do_w = ($urandom_range(0, 3) == 0);
      send(ch, x, do_w, wsel, v, k);
      if ($urandom_range(0, 1) == 1) begin
        wsel = int'($urandom_range(0, 7));
        v    = 32'($urandom_range(0, 32'h00008000)) - 32'h00004000;
        wcoef((ch + 1 + int'($urandom_range(0, N_CH - 2))) % N_CH, wsel, v);
      end
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
